wb_master_arbiter_rr: RTL and testbench
=======================================

Name: wb_master_arbiter_rr

Overview:
Parametrised round-robin Wishbone master arbiter. It grants the shared bus to one of NUM_MASTERS masters based on their cyc requests. It gates the winner's cyc through to the syscon/interconnect and holds the grant until that master drops cyc. It replaces the fixed 4-master rotating-selector arbiter, which wasted cycles polling idle masters and had no grant visibility or fairness guarantee.

Parameters:
NUM_MASTERS, 4, number of requesting masters; legal range 2..16.
IDX_W, 2, width of grant index; must be set to ceil(log2(NUM_MASTERS)).
MAX_HOLD, 64, maximum grant length in cycles while another master is waiting; used only with the optional feature; legal range 1..65535.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
m_cyc_i  in  NUM_MASTERS  cyc request per master, bit i = master i
m_cyc_o  out  NUM_MASTERS  gated cyc to interconnect, one-hot or zero
grant_valid  out  1  bus currently owned
grant_idx  out  IDX_W  index of the owning master; 0 when grant_valid=0
hold_timeout  out  1  one-cycle pulse on forced release; exists only with WB_ARB_HOLD_LIMIT_EN

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values (while rst_n=0): grant_valid=0, grant_idx=0, m_cyc_o=0, last_idx=NUM_MASTERS-1 (so master 0 has first priority), hold counter=0, hold_timeout=0.
- State machine: two states, IDLE and OWNED. Grant state is registered. m_cyc_o[i] = m_cyc_i[i] AND (grant_valid AND grant_idx==i), combinational.
- IDLE -> OWNED: at a rising edge with any m_cyc_i bit high. The winner is the first requester found scanning from last_idx+1 upward, wrapping from NUM_MASTERS-1 to 0.
- Latency: a request raised in cycle t on an idle bus gives grant_valid=1 and m_cyc_o high in cycle t+1.
- OWNED, owner's m_cyc_i high: grant holds; no other master is visible on m_cyc_o.
- OWNED, owner's m_cyc_i low at an edge: the owner is released at that edge.
  - last_idx <= owner.
  - At the same edge, re-arbitrate among requesters, scanning from owner+1. The owner itself is scanned last.
  - No dead cycle between back-to-back owners.
  - If there are no requesters, go to IDLE.
- Fairness: with all masters requesting continuously and each releasing after one transfer, grants rotate 0,1,2,...,N-1,0. No master waits more than N-1 tenures.
- Simultaneous events: the owner drops and a new request arrives at the same edge -> the new request is eligible at that edge.
- Owner drops cyc for one cycle and reasserts: it loses ownership if any other master was requesting at the release edge.
- Reset mid-transfer: m_cyc_o goes to 0 immediately (asynchronous). After rst_n deasserts, arbitration restarts from master 0.
- Non-power-of-two NUM_MASTERS: indices >= NUM_MASTERS are never produced; the scan wraps at NUM_MASTERS-1.
- Granted master index out of range or X on m_cyc_i: not checked; behaviour is undefined.

Optional Feature:
Macro: WB_ARB_HOLD_LIMIT_EN.
- Defined:
  - A 16-bit hold counter clears on every new grant.
  - It increments each OWNED cycle in which any non-owner requests, and saturates.
  - When the counter reaches MAX_HOLD, the owner is force-released at that edge, exactly as if it had dropped cyc, and hold_timeout pulses high for 1 cycle.
  - The force-released master's m_cyc_o drops in the next cycle. That master must abort its cycle and re-request.
  - The counter does not advance while no other master is requesting, so a lone master holds indefinitely.
- Undefined: no counter and no hold_timeout port. A master holds the bus until it drops cyc.

Test Plan:
- Reset/first grant: assert rst_n=0 then release; raise m_cyc_i=4'b0100 at cycle t -> cycle t+1: grant_valid=1, grant_idx=2, m_cyc_o=4'b0100. Assert rst_n=0 mid-grant -> m_cyc_o=0 the same cycle.
- Round-robin rotation: NUM_MASTERS=4, m_cyc_i=4'b1111, each owner holds 3 cycles then drops for 1 -> grant_idx sequence 0,1,2,3,0, with no idle cycle between owners.
- Wrap and skip: last owner=3, requests m_cyc_i=4'b0101 -> next grant_idx=0, then 2; master 1 and master 3 are never granted.
- Owner re-request: master 1 owns; it drops cyc for 1 cycle while master 3 requests -> grant moves to 3. Master 1 drops while no one else requests -> it is re-granted the cycle after it reasserts.
- Non-power-of-two: NUM_MASTERS=3, IDX_W=2, all requesting -> grant_idx cycles 0,1,2,0 and never shows 3.
- Hold limit (WB_ARB_HOLD_LIMIT_EN, MAX_HOLD=8): master 0 holds cyc high, master 2 requests from grant+1 -> hold_timeout pulses at the 8th waiting cycle and grant_idx=2 the next cycle. With no other requester, master 0 holds for 100 cycles with no pulse.

Source files
------------

// File: rtl/wb_master_arbiter_rr.sv
`default_nettype none
// ============================================================================
// wb_master_arbiter_rr : round-robin Wishbone master arbiter, grant held until
// the owner drops cyc. Optional WB_ARB_HOLD_LIMIT_EN caps contended tenure.
// Revision: 1.0
// ============================================================================
module wb_master_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = 2,
  parameter int MAX_HOLD    = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] m_cyc_i,
  output logic [NUM_MASTERS-1:0] m_cyc_o,
  output logic                   grant_valid,
  output logic [IDX_W-1:0]       grant_idx
`ifdef WB_ARB_HOLD_LIMIT_EN
  ,
  output logic                   hold_timeout
`endif
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_OWNED = 1'b1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W+1)'(NUM_MASTERS);

  generate
    if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || IDX_W != $clog2(NUM_MASTERS) ||
        MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_params
      $error("wb_master_arbiter_rr: illegal parameter set");
    end
  endgenerate

  logic [0:0]             state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [NUM_MASTERS-1:0] owner_mask;
  logic                   others_req;
  logic                   release_owner;
  logic                   force_release;
  logic [IDX_W-1:0]       scan_base;
  logic [IDX_W:0]         scan_cand;
  logic [IDX_W-1:0]       scan_win;
  logic                   scan_hit;

  assign owner_mask = NUM_MASTERS'(1) << owner_q;
  assign others_req = |(m_cyc_i & ~owner_mask);

`ifdef WB_ARB_HOLD_LIMIT_EN
  localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);
  logic [15:0] hold_cnt_q, hold_cnt_d;

  // Fires on the edge at which the counter would reach MAX_HOLD.
  assign force_release = (state_q == ST_OWNED) && others_req && (hold_cnt_q >= HOLD_LAST);
`else
  assign force_release = 1'b0;
`endif

  assign release_owner = (state_q == ST_OWNED) && (!m_cyc_i[owner_q] || force_release);

  // Scan starts one past the base and ends on the base itself, so a released
  // owner is always considered last.
  assign scan_base = (state_q == ST_OWNED) ? owner_q : last_q;

  always_comb begin
    scan_win  = '0;
    scan_hit  = 1'b0;
    scan_cand = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      scan_cand = {1'b0, scan_base} + (IDX_W+1)'(k);
      if (scan_cand >= N_EXT) begin
        scan_cand = scan_cand - N_EXT;
      end
      if (!scan_hit && m_cyc_i[scan_cand[IDX_W-1:0]]) begin
        scan_win = scan_cand[IDX_W-1:0];
        scan_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      last_q     <= LAST_RST;
`ifdef WB_ARB_HOLD_LIMIT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
`ifdef WB_ARB_HOLD_LIMIT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
`ifdef WB_ARB_HOLD_LIMIT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (scan_hit) begin
          state_d    = ST_OWNED;
          owner_d    = scan_win;
`ifdef WB_ARB_HOLD_LIMIT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      ST_OWNED: begin
        if (release_owner) begin
          last_d     = owner_q;
`ifdef WB_ARB_HOLD_LIMIT_EN
          hold_cnt_d = '0;
`endif
          if (scan_hit) begin
            owner_d = scan_win;
          end else begin
            state_d = ST_IDLE;
            owner_d = '0;
          end
        end
`ifdef WB_ARB_HOLD_LIMIT_EN
        else if (others_req && (hold_cnt_q != 16'hFFFF)) begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = '0;
      end
    endcase
  end

  always_comb begin
    grant_valid  = (state_q == ST_OWNED);
    grant_idx    = owner_q;
    m_cyc_o      = grant_valid ? (m_cyc_i & owner_mask) : '0;
`ifdef WB_ARB_HOLD_LIMIT_EN
    hold_timeout = force_release;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_master_arbiter_rr.sv
`default_nettype none
// ============================================================================
// tb_wb_master_arbiter_rr : directed bench for a 4-master and a 3-master
// arbiter, checked every cycle against a queue-free behavioural model.
// Revision: 1.0
// ============================================================================
module tb_wb_master_arbiter_rr;

  localparam int MAX_HOLD = 8;
`ifdef WB_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req4 = '0;
  logic [2:0] req3 = '0;
  logic [3:0] cyc4;
  logic [2:0] cyc3;
  logic       gv4, gv3;
  logic [1:0] gi4, gi3;
  logic       ht4, ht3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_master_arbiter_rr #(.NUM_MASTERS(4), .IDX_W(2), .MAX_HOLD(MAX_HOLD)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .m_cyc_i(req4), .m_cyc_o(cyc4),
    .grant_valid(gv4), .grant_idx(gi4)
`ifdef WB_ARB_HOLD_LIMIT_EN
    , .hold_timeout(ht4)
`endif
  );

  wb_master_arbiter_rr #(.NUM_MASTERS(3), .IDX_W(2), .MAX_HOLD(MAX_HOLD)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .m_cyc_i(req3), .m_cyc_o(cyc3),
    .grant_valid(gv3), .grant_idx(gi3)
`ifdef WB_ARB_HOLD_LIMIT_EN
    , .hold_timeout(ht3)
`endif
  );

`ifndef WB_ARB_HOLD_LIMIT_EN
  assign ht4 = 1'b0;
  assign ht3 = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: owner is -1 when the bus is free.
  int m_owner[2] = '{-1, -1};
  int m_last[2]  = '{3, 2};
  int m_cnt[2]   = '{0, 0};

  function automatic int n_of(input int j);
    return (j == 0) ? 4 : 3;
  endfunction

  function automatic logic [3:0] req_of(input int j);
    return (j == 0) ? req4 : {1'b0, req3};
  endfunction

  function automatic int pick(input int n, input int base, input logic [3:0] req);
    for (int k = 1; k <= n; k++) begin
      int c;
      c = (base + k) % n;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit others_of(input int o, input logic [3:0] r);
    return (o >= 0) && (|(r & ~(4'b0001 << o)));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int o, l, c, n;
    logic [3:0] r;
    bit oth, tmo;
    for (int j = 0; j < 2; j++) begin
      if (!rst_n) begin
        m_owner[j] <= -1;
        m_last[j]  <= n_of(j) - 1;
        m_cnt[j]   <= 0;
      end else begin
        n = n_of(j);
        r = req_of(j);
        o = m_owner[j];
        l = m_last[j];
        c = m_cnt[j];
        if (o < 0) begin
          o = pick(n, l, r);
          c = 0;
        end else begin
          oth = others_of(o, r);
          tmo = HOLD_EN && oth && (c + 1 >= MAX_HOLD);
          if (!r[o] || tmo) begin
            l = o;
            o = pick(n, o, r);
            c = 0;
          end else if (oth && c < 65535) begin
            c = c + 1;
          end
        end
        m_owner[j] <= o;
        m_last[j]  <= l;
        m_cnt[j]   <= c;
      end
    end
  end

  always @(negedge clk) begin
    int o;
    logic [3:0] r;
    for (int j = 0; j < 2; j++) begin
      o = m_owner[j];
      r = req_of(j);
      check(j == 0 ? "m4_grant_valid" : "m3_grant_valid", j == 0 ? gv4 : gv3, o >= 0);
      check(j == 0 ? "m4_grant_idx" : "m3_grant_idx", j == 0 ? gi4 : gi3, (o >= 0) ? o : 0);
      check(j == 0 ? "m4_cyc_o" : "m3_cyc_o", j == 0 ? cyc4 : {1'b0, cyc3},
            (o >= 0) ? (r & (4'b0001 << o)) : 4'b0000);
      check(j == 0 ? "m4_hold_timeout" : "m3_hold_timeout", j == 0 ? ht4 : ht3,
            HOLD_EN && others_of(o, r) && (m_cnt[j] + 1 >= MAX_HOLD));
    end
  end

  int rot_seq[5] = '{0, 1, 2, 3, 0};
  int rot3_seq[4] = '{0, 1, 2, 0};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_grant_valid", gv4, 0);
    check("reset_grant_idx", gi4, 0);
    check("reset_cyc_o", cyc4, 0);
    rst_n = 1'b1;
    tick();

    req4 = 4'b0100;
    #1 check("pre_grant_cyc_o", cyc4, 4'b0000);
    tick();
    check("first_grant_valid", gv4, 1);
    check("first_grant_idx", gi4, 2);
    check("first_grant_cyc_o", cyc4, 4'b0100);
    tick();
    #2 rst_n = 1'b0;
    #1 check("async_reset_cyc_o", cyc4, 4'b0000);
    check("async_reset_valid", gv4, 0);
    tick();
    req4 = 4'b1111;
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) begin
      for (int h = 0; h < 3; h++) begin
        check("rotate_idx", gi4, rot_seq[k]);
        tick();
      end
      req4 = 4'b1111 & ~(4'b0001 << rot_seq[k]);
      #1 check("rotate_no_gap", gv4, 1);
      tick();
      req4 = 4'b1111;
    end

    req4 = 4'b1000;
    tick();
    check("wrap_owner3", gi4, 3);
    req4 = 4'b0000;
    tick();
    check("wrap_idle", gv4, 0);
    req4 = 4'b0101;
    tick();
    check("wrap_to_0", gi4, 0);
    tick();
    req4 = 4'b0100;
    tick();
    check("skip_to_2", gi4, 2);
    req4 = 4'b0101;
    tick();
    check("hold_2", gi4, 2);
    req4 = 4'b0001;
    tick();
    check("skip_back_0", gi4, 0);
    req4 = 4'b0000;
    tick();

    req4 = 4'b0010;
    tick();
    check("rereq_owner1", gi4, 1);
    req4 = 4'b1000;
    tick();
    check("rereq_moves_3", gi4, 3);
    req4 = 4'b1010;
    tick();
    check("rereq_3_holds", gi4, 3);
    req4 = 4'b0000;
    tick();
    req4 = 4'b0010;
    tick();
    check("rereq_own1_again", gi4, 1);
    req4 = 4'b0000;
    tick();
    check("rereq_released", gv4, 0);
    req4 = 4'b0010;
    tick();
    check("rereq_regrant_valid", gv4, 1);
    check("rereq_regrant_idx", gi4, 1);
    req4 = 4'b0000;
    tick();

    req3 = 3'b111;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("n3_idx", gi3, rot3_seq[k]);
      req3 = 3'b111 & ~(3'b001 << rot3_seq[k]);
      tick();
      req3 = 3'b111;
    end
    req3 = 3'b000;
    tick();

`ifdef WB_ARB_HOLD_LIMIT_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req4 = 4'b0001;
    tick();
    check("hold_owner0", gi4, 0);
    req4 = 4'b0101;
    for (int w = 1; w <= 8; w++) begin
      #1 check("hold_pulse", ht4, (w == 8));
      tick();
    end
    check("hold_new_owner", gi4, 2);
    check("hold_pulse_gone", ht4, 0);
    check("hold_cyc_o", cyc4, 4'b0100);
    req4 = 4'b0001;
    tick();
    for (int w = 0; w < 100; w++) begin
      check("lone_no_pulse", ht4, 0);
      tick();
    end
    check("lone_still_owner", gi4, 0);
    check("lone_still_valid", gv4, 1);
    req4 = 4'b0000;
    tick();
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
